// File: rtl/approx_sub_pkg.sv
// Shared types, constants and sizing helpers for the digit-serial approximate subtractor.
package approx_sub_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t RUN  = 2'd1;
   localparam state_t DONE = 2'd2;

   localparam int DIGIT_W = 2;

   function automatic int digit_count(input int w);
      return w / DIGIT_W;
   endfunction

   // A single-digit operand still needs a one-bit counter.
   function automatic int cnt_width(input int w);
      return (digit_count(w) > 1) ? $clog2(digit_count(w)) : 1;
   endfunction

endpackage

// File: rtl/paa2_digit.sv
// PAA2 approximate 2-bit adder cell: exact sum bits, carry-out taken as c1 | (x1 & y1).
module paa2_digit
   import approx_sub_pkg::*;
(
   input  logic [DIGIT_W-1:0] x,
   input  logic [DIGIT_W-1:0] y,
   input  logic               cin,
   output logic [DIGIT_W-1:0] s,
   output logic               cout
);

   logic c1;

   always_comb begin
      c1   = ((x[0] ^ y[0]) & cin) | (x[0] & y[0]);
      s    = {x[1] ^ y[1] ^ c1, x[0] ^ y[0] ^ cin};
      cout = c1 | (x[1] & y[1]);
   end

endmodule

// File: rtl/approx_serial_sub2.sv
// Digit-serial approximate subtractor (a + ~b + 1), two bits per clock, LSB digit first.
// Define APPROX_SUB_ERR_MON_EN to add the exact-chain monitor outputs out_exact and err.
module approx_serial_sub2
   import approx_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             borrow
`ifdef APPROX_SUB_ERR_MON_EN
   ,
   output logic [WIDTH-1:0] out_exact,
   output logic [0:0]       err
`endif
);

   localparam int DIGITS = digit_count(WIDTH);
   localparam int CW     = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

   generate
      if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
         $error("approx_serial_sub2: WIDTH must be even and >= 2");
      end
   endgenerate

   state_t              state;
   logic [CW-1:0]       cnt;
   logic                carry;
   logic [WIDTH-1:0]    a_sh;
   logic [WIDTH-1:0]    nb_sh;
   logic [WIDTH-1:0]    res;
   logic                borrow_r;
   logic [DIGIT_W-1:0]  dig_s;
   logic                dig_c;
   logic                accept;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && (state == IDLE);
   assign out       = res;
   assign borrow    = borrow_r;

   paa2_digit u_digit (
      .x    (a_sh[DIGIT_W-1:0]),
      .y    (nb_sh[DIGIT_W-1:0]),
      .cin  (carry),
      .s    (dig_s),
      .cout (dig_c)
   );

   // Operand shift registers are pure data; the FSM decides when their contents matter.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_sh  <= in0;
         nb_sh <= ~in1;
      end else if (state == RUN) begin
         a_sh  <= a_sh >> DIGIT_W;
         nb_sh <= nb_sh >> DIGIT_W;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         carry    <= 1'b0;
         res      <= '0;
         borrow_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  carry <= 1'b1;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               res[{cnt, 1'b0} +: DIGIT_W] <= dig_s;
               carry <= dig_c;
               cnt   <= cnt + CW'(1);
               if (cnt == LAST) begin
                  borrow_r <= ~dig_c;
                  state    <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef APPROX_SUB_ERR_MON_EN
   logic             carry_e;
   logic [WIDTH-1:0] res_e;
   logic             borrow_e;
   logic             ex_c1;
   logic             ex_c;
   logic [1:0]       ex_s;

   // Same digit inputs as the approximate cell, but with the fully propagated carry.
   always_comb begin
      ex_c1 = ((a_sh[0] ^ nb_sh[0]) & carry_e) | (a_sh[0] & nb_sh[0]);
      ex_s  = {a_sh[1] ^ nb_sh[1] ^ ex_c1, a_sh[0] ^ nb_sh[0] ^ carry_e};
      ex_c  = ((a_sh[1] ^ nb_sh[1]) & ex_c1) | (a_sh[1] & nb_sh[1]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carry_e  <= 1'b0;
         res_e    <= '0;
         borrow_e <= 1'b0;
      end else if (accept) begin
         carry_e <= 1'b1;
      end else if (state == RUN) begin
         res_e[{cnt, 1'b0} +: DIGIT_W] <= ex_s;
         carry_e <= ex_c;
         if (cnt == LAST) begin
            borrow_e <= ~ex_c;
         end
      end
   end

   assign out_exact = res_e;
   assign err       = out_valid && ((res != res_e) || (borrow_r != borrow_e));
`endif

endmodule

// File: tb/tb_approx_serial_sub2.sv
// Directed, table-driven bench for approx_serial_sub2 (WIDTH=8) plus multi-cycle corner sequences.
module tb_approx_serial_sub2;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in0;
   logic [7:0] in1;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out;
   logic       borrow;
`ifdef APPROX_SUB_ERR_MON_EN
   logic [7:0] out_exact;
   logic [0:0] err;
`endif

   int tests = 0;
   int fails = 0;

   approx_serial_sub2 #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in0       (in0),
      .in1       (in1),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .borrow    (borrow)
`ifdef APPROX_SUB_ERR_MON_EN
      ,
      .out_exact (out_exact),
      .err       (err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] exp_out;
      logic       exp_borrow;
      logic [7:0] exp_exact;
      logic       exp_err;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Present operands, wait for acceptance, scramble the inputs, then count cycles to out_valid.
   task automatic start_op(input logic [7:0] a, input logic [7:0] b, output int lat);
      int n;
      @(negedge clk);
      in0 = a; in1 = b; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in0 = ~a;
      in1 = a ^ 8'h5A;
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic finish_op(input string name);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({name, "_drop"}, {31'd0, out_valid}, 32'd0);
      check({name, "_idle"}, {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      int lat;
      int bad;
      bit seen_valid;

      vecs[0] = '{8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1, 8'hFF, 1'b0};
      vecs[2] = '{8'h05, 8'h03, 8'h06, 1'b0, 8'h02, 1'b1};
      vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0};
      vecs[4] = '{8'h03, 8'h01, 8'h02, 1'b0, 8'h02, 1'b0};
      vecs[5] = '{8'h01, 8'h02, 8'h03, 1'b0, 8'hFF, 1'b1};
      vecs[6] = '{8'h80, 8'h7F, 8'h01, 1'b0, 8'h01, 1'b0};
      vecs[7] = '{8'hAA, 8'h55, 8'h55, 1'b0, 8'h55, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in0 = '0; in1 = '0;
      repeat (3) @(negedge clk);
      check("rst_in_ready",  {31'd0, in_ready},  32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out",       {24'd0, out},       32'd0);
      check("rst_borrow",    {31'd0, borrow},    32'd0);
`ifdef APPROX_SUB_ERR_MON_EN
      check("rst_out_exact", {24'd0, out_exact}, 32'd0);
      check("rst_err",       {31'd0, err},       32'd0);
`endif
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         start_op(vecs[i].a, vecs[i].b, lat);
         check($sformatf("v%0d_latency", i), lat, 32'd4);
         check($sformatf("v%0d_out", i), {24'd0, out}, {24'd0, vecs[i].exp_out});
         check($sformatf("v%0d_borrow", i), {31'd0, borrow}, {31'd0, vecs[i].exp_borrow});
         check($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd0);
`ifdef APPROX_SUB_ERR_MON_EN
         check($sformatf("v%0d_exact", i), {24'd0, out_exact}, {24'd0, vecs[i].exp_exact});
         check($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
`endif
         finish_op($sformatf("v%0d", i));
      end

      // Backpressure: result must sit unchanged for ten cycles.
      start_op(8'hFF, 8'hFF, lat);
      check("bp_latency", lat, 32'd4);
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         in0 = 8'(c * 37); in1 = 8'(c * 11 + 3);
         if (out !== 8'h00 || borrow !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
      end
      check("bp_stable_cycles_bad", bad, 32'd0);
      finish_op("bp");

      // Reset in the middle of RUN aborts the operation asynchronously.
      @(negedge clk);
      in0 = 8'h05; in1 = 8'h03; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      check("abort_in_ready",  {31'd0, in_ready},  32'd1);
      check("abort_out",       {24'd0, out},       32'd0);
      check("abort_borrow",    {31'd0, borrow},    32'd0);
      seen_valid = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (out_valid) seen_valid = 1'b1;
      end
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (out_valid) seen_valid = 1'b1;
      end
      check("abort_no_valid", {31'd0, seen_valid}, 32'd0);
      start_op(8'h00, 8'h01, lat);
      check("post_abort_latency", lat, 32'd4);
      check("post_abort_out",    {24'd0, out},    32'h0000_00FF);
      check("post_abort_borrow", {31'd0, borrow}, 32'd1);
      finish_op("post_abort");

      // Back-to-back with in_valid held high: second request waits for the first handshake.
      @(negedge clk);
      in0 = 8'h00; in1 = 8'h00; in_valid = 1'b1;
      @(negedge clk);
      in1 = 8'h01;
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      check("b2b_first_latency", lat, 32'd4);
      check("b2b_first_out",     {24'd0, out},    32'd0);
      check("b2b_first_borrow",  {31'd0, borrow}, 32'd0);
      check("b2b_first_in_ready", {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1;
      @(negedge clk);
      check("b2b_gap_valid", {31'd0, out_valid}, 32'd0);
      check("b2b_gap_ready", {31'd0, in_ready},  32'd1);
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b0;
      check("b2b_second_accepted", {31'd0, in_ready}, 32'd0);
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      check("b2b_second_latency", lat, 32'd4);
      check("b2b_second_out",    {24'd0, out},    32'h0000_00FF);
      check("b2b_second_borrow", {31'd0, borrow}, 32'd1);
      finish_op("b2b_second");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/approx_serial_sub2.md
Name: approx_serial_sub2

Overview:
- Digit-serial approximate subtractor: computes diff = a - b as a + ~b + 1, two bits per clock, LSB digit first.
- Each digit uses the team's PAA2 approximate 2-bit cell: sum bits exact, digit carry-out approximated as c1 | (x1 & y1).
- It is the inverse-direction companion to the combinational PAA2 adder, for error characterisation of subtract paths in the approximate datapath.
- Valid/ready on both sides; one operation in flight.

Parameters:
- WIDTH, 8, operand/result width; must be even and >= 2 (elaboration error otherwise).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- in0  input  WIDTH  minuend a
- in1  input  WIDTH  subtrahend b
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out  output  WIDTH  approximate difference
- borrow  output  1  inverse of the final approximate carry (1 = approximate a < b)

Behaviour:
- Clocking: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out=0, borrow=0, digit counter=0, carry register=0.
- State IDLE:
  - in_ready=1.
  - On in_valid & in_ready: capture a and ~b in shift registers, set carry=1, clear counter, go to RUN.
- State RUN:
  - in_ready=0.
  - Each cycle, process digit k with x=a[2k+1:2k], y=~b[2k+1:2k], cin=carry.
  - s0 = x0^y0^cin
  - c1 = (x0^y0)&cin | x0&y0
  - s1 = x1^y1^c1
  - cout = c1 | x1&y1
  - Write {s1,s0} into result bits [2k+1:2k]; carry <= cout.
  - After digit WIDTH/2-1, go to DONE.
- State DONE:
  - out_valid=1; out and borrow stable, borrow = ~final carry.
  - On out_ready: out_valid drops next cycle, return to IDLE.
  - Backpressure: hold indefinitely with out/borrow stable; in_ready stays 0.
- Latency: accept edge E; out_valid high after edge E+WIDTH/2 (4 cycles for WIDTH=8).
- Throughput: one result per WIDTH/2+2 cycles minimum.
- Input changes while not in IDLE are ignored.
- in_valid is sampled only while in_ready=1; a request held across DONE is accepted in the IDLE cycle that follows.
- Reset asserted mid-RUN or mid-DONE aborts the operation immediately, returns to reset values, and no partial result is presented.
- WIDTH=2: RUN lasts exactly one cycle.

Optional Feature:
- Macro: APPROX_SUB_ERR_MON_EN.
- Defined:
  - Adds output port out_exact [WIDTH-1:0], the exact a-b computed by a parallel exact-carry digit chain.
  - Adds output port err [0:0], high when out != out_exact or borrow != exact borrow.
  - Both new outputs are valid with out_valid and reset to 0.
- Undefined: neither port exists; no exact chain logic.

Decomposition:
- Package approx_sub_pkg holds:
  - the state enum (IDLE, RUN, DONE)
  - DIGIT_W = 2
  - the digit-count function WIDTH/2
  - the counter width $clog2(WIDTH/2) (min 1)
- Sub-module paa2_digit: combinational 2-bit approximate cell. Inputs x[1:0], y[1:0], cin; outputs s[1:0], cout. Instantiated once in the serial datapath.

Test Plan (WIDTH=8):
- a=0x00, b=0x00 -> out=0x00, borrow=0, out_valid 4 cycles after accept; with macro, err=0.
- a=0x00, b=0x01 -> out=0xFF, borrow=1; with macro, out_exact=0xFF, err=0.
- a=0x05, b=0x03 -> out=0x06, borrow=0 (approximate carry on digit 0); with macro, out_exact=0x02, err=1.
- a=0xFF, b=0xFF with out_ready held low 10 cycles -> out=0x00 and borrow=0 held stable, in_ready=0 throughout; out_valid drops the cycle after out_ready=1.
- Accept a=0x05, b=0x03, pull rst_n low 2 cycles after accept -> outputs take reset values asynchronously, out_valid never asserts. Then a=0x00, b=0x01 -> out=0xFF, borrow=1.
- Back-to-back: in_valid held high with a=0x00/b=0x00 then a=0x00/b=0x01 -> two results in order, second accepted only after the first handshake completes.
